// File: rtl/dcache_mshr_ooo.sv
// Miss-status holding registers for a non-blocking data cache.
// Tracks up to ENTRIES outstanding line misses. Secondary misses to a live line
// merge into its entry. Refill requests go to L2 strictly in allocation order.
// Refill responses may come back in any order, tagged by entry index.
module dcache_mshr_ooo #(
    parameter int ENTRIES     = 4,
    parameter int LINE_ADDR_W = 58,
    parameter int MERGE_W     = 2,
    localparam int IDX_W      = $clog2(ENTRIES),
    localparam int CNT_W      = $clog2(ENTRIES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   alloc_valid_i,
    input  logic [LINE_ADDR_W-1:0] alloc_addr_i,
    output logic                   alloc_ready_o,
    output logic                   alloc_hit_o,
    output logic [IDX_W-1:0]       alloc_idx_o,
    output logic                   l2_req_valid_o,
    input  logic                   l2_req_ready_i,
    output logic [LINE_ADDR_W-1:0] l2_req_addr_o,
    output logic [IDX_W-1:0]       l2_req_id_o,
    input  logic                   l2_rsp_valid_i,
    input  logic [IDX_W-1:0]       l2_rsp_id_i,
    output logic                   done_o,
    output logic [LINE_ADDR_W-1:0] done_addr_o,
    output logic [MERGE_W-1:0]     done_merge_o,
    output logic                   rsp_err_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [CNT_W-1:0]       pending_cnt_o
);

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_ISSUE = 2'd1,
        WAIT_RSP   = 2'd2
    } entryState_t;

    // Per-entry storage
    entryState_t            r_state [ENTRIES];
    logic [LINE_ADDR_W-1:0] r_addr  [ENTRIES];
    logic [MERGE_W-1:0]     r_merge [ENTRIES];

    // Issue-order FIFO of entry indices; it can never overflow because an index
    // is pushed only when its entry leaves FREE
    logic [IDX_W-1:0]       r_fifo  [ENTRIES];
    logic [IDX_W-1:0]       r_head;
    logic [IDX_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    // Registered completion and error reporting
    logic                   r_done;
    logic [LINE_ADDR_W-1:0] r_doneAddr;
    logic [MERGE_W-1:0]     r_doneMerge;
    logic                   r_rspErr;

    // Combinational helpers
    entryState_t            w_stateNxt [ENTRIES];
    logic [LINE_ADDR_W-1:0] w_addrNxt  [ENTRIES];
    logic [MERGE_W-1:0]     w_mergeNxt [ENTRIES];
    logic [ENTRIES-1:0]     w_live;
    logic                   w_rspHit;
    logic                   w_anyFree;
    logic                   w_allFree;
    logic [IDX_W-1:0]       w_freeIdx;
    logic                   w_hitAny;
    logic [IDX_W-1:0]       w_hitIdx;
    logic [CNT_W-1:0]       w_pendCnt;
    logic [IDX_W-1:0]       w_headIdx;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_merge;

    assign w_rspHit  = l2_rsp_valid_i && (r_state[l2_rsp_id_i] == WAIT_RSP);
    assign w_headIdx = r_fifo[r_head];

    // Find the lowest-index FREE entry using registered state only, so an entry
    // freed by a response this cycle is not handed out until the next cycle
    always_comb begin
        w_anyFree = 1'b0;
        w_allFree = 1'b1;
        w_freeIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == FREE) begin
                w_anyFree = 1'b1;
                w_freeIdx = IDX_W'(i);
            end else begin
                w_allFree = 1'b0;
            end
        end
    end

    // Address match against live entries; a WAIT_RSP entry completing this
    // cycle is no longer live, so a miss to its line allocates afresh
    always_comb begin
        w_live   = '0;
        w_hitAny = 1'b0;
        w_hitIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_live[i] = (r_state[i] == WAIT_ISSUE) ||
                        ((r_state[i] == WAIT_RSP) && !(w_rspHit && (l2_rsp_id_i == IDX_W'(i))));
            if (w_live[i] && (r_addr[i] == alloc_addr_i)) begin
                w_hitAny = 1'b1;
                w_hitIdx = IDX_W'(i);
            end
        end
    end

    // Count entries waiting for their refill
    always_comb begin
        w_pendCnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_state[i] == WAIT_RSP) begin
                w_pendCnt = w_pendCnt + CNT_W'(1);
            end
        end
    end

    assign w_merge = alloc_valid_i && w_hitAny;
    assign w_push  = alloc_valid_i && !w_hitAny && w_anyFree;
    assign w_pop   = (r_count != '0) && l2_req_ready_i;

    // Entry next-state: issue, completion, merge and allocation touch disjoint
    // fields or disjoint entries, and flush overrides everything
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_stateNxt[i] = r_state[i];
            w_addrNxt[i]  = r_addr[i];
            w_mergeNxt[i] = r_merge[i];
        end
        if (w_pop) begin
            w_stateNxt[w_headIdx] = WAIT_RSP;
        end
        if (w_rspHit) begin
            w_stateNxt[l2_rsp_id_i] = FREE;
        end
        if (w_merge && (r_merge[w_hitIdx] != {MERGE_W{1'b1}})) begin
            w_mergeNxt[w_hitIdx] = r_merge[w_hitIdx] + MERGE_W'(1);
        end
        if (w_push) begin
            w_stateNxt[w_freeIdx] = WAIT_ISSUE;
            w_addrNxt[w_freeIdx]  = alloc_addr_i;
            w_mergeNxt[w_freeIdx] = '0;
        end
        if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                w_stateNxt[i] = FREE;
                w_addrNxt[i]  = '0;
                w_mergeNxt[i] = '0;
            end
        end
    end

    // Entry state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= FREE;
                r_addr[i]  <= '0;
                r_merge[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= w_stateNxt[i];
                r_addr[i]  <= w_addrNxt[i];
                r_merge[i] <= w_mergeNxt[i];
            end
        end
    end

    // Issue FIFO: push on a new allocation, pop on the L2 handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_fifo[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= w_freeIdx;
                r_tail         <= r_tail + IDX_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + IDX_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // One-cycle completion and illegal-response pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done      <= 1'b0;
            r_doneAddr  <= '0;
            r_doneMerge <= '0;
            r_rspErr    <= 1'b0;
        end else if (flush_i) begin
            r_done      <= 1'b0;
            r_doneAddr  <= '0;
            r_doneMerge <= '0;
            r_rspErr    <= 1'b0;
        end else begin
            r_done   <= w_rspHit;
            r_rspErr <= l2_rsp_valid_i && !w_rspHit;
            if (w_rspHit) begin
                r_doneAddr  <= r_addr[l2_rsp_id_i];
                r_doneMerge <= r_merge[l2_rsp_id_i];
            end
        end
    end

    assign alloc_hit_o    = alloc_valid_i && w_hitAny;
    assign alloc_ready_o  = alloc_hit_o || w_anyFree;
    assign alloc_idx_o    = w_hitAny ? w_hitIdx : w_freeIdx;

    assign l2_req_valid_o = (r_count != '0);
    assign l2_req_id_o    = w_headIdx;
    assign l2_req_addr_o  = r_addr[w_headIdx];

    assign done_o         = r_done;
    assign done_addr_o    = r_doneAddr;
    assign done_merge_o   = r_doneMerge;
    assign rsp_err_o      = r_rspErr;

    assign full_o         = !w_anyFree;
    assign empty_o        = w_allFree;
    assign pending_cnt_o  = w_pendCnt;

endmodule

// File: tb/tb_dcache_mshr_ooo.sv
// Directed testbench for dcache_mshr_ooo with ENTRIES=4, MERGE_W=2.
// Inputs change 1 time unit after a rising edge. Combinational outputs are checked
// 1 unit later. Registered outputs are checked 1 unit after the next rising edge.
module tb_dcache_mshr_ooo;

    localparam int ENTRIES = 4;
    localparam int AW      = 58;
    localparam int MW      = 2;
    localparam int IW      = 2;
    localparam int CW      = 3;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          allocValid;
    logic [AW-1:0] allocAddr;
    logic          allocReady;
    logic          allocHit;
    logic [IW-1:0] allocIdx;
    logic          reqValid;
    logic          reqReady;
    logic [AW-1:0] reqAddr;
    logic [IW-1:0] reqId;
    logic          rspValid;
    logic [IW-1:0] rspId;
    logic          done;
    logic [AW-1:0] doneAddr;
    logic [MW-1:0] doneMerge;
    logic          rspErr;
    logic          full;
    logic          empty;
    logic [CW-1:0] pendCnt;

    int assertCnt = 0;
    int failCnt   = 0;

    dcache_mshr_ooo #(.ENTRIES(ENTRIES), .LINE_ADDR_W(AW), .MERGE_W(MW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .alloc_valid_i  (allocValid),
        .alloc_addr_i   (allocAddr),
        .alloc_ready_o  (allocReady),
        .alloc_hit_o    (allocHit),
        .alloc_idx_o    (allocIdx),
        .l2_req_valid_o (reqValid),
        .l2_req_ready_i (reqReady),
        .l2_req_addr_o  (reqAddr),
        .l2_req_id_o    (reqId),
        .l2_rsp_valid_i (rspValid),
        .l2_rsp_id_i    (rspId),
        .done_o         (done),
        .done_addr_o    (doneAddr),
        .done_merge_o   (doneMerge),
        .rsp_err_o      (rspErr),
        .full_o         (full),
        .empty_o        (empty),
        .pending_cnt_o  (pendCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input for the coming cycle, then let combinational outputs settle
    task automatic applyStimulus(input logic av, input logic [AW-1:0] aa, input logic rr,
                                 input logic rv, input logic [IW-1:0] rid, input logic fl);
        allocValid = av;
        allocAddr  = aa;
        reqReady   = rr;
        rspValid   = rv;
        rspId      = rid;
        flush      = fl;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCnt++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #12;
        // Reset values
        checkOutput("rst_reqValid", reqValid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", rspErr, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_pend", pendCnt, 0);
        checkOutput("rst_doneAddr", doneAddr, 0);
        checkOutput("rst_doneMerge", doneMerge, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // In-order issue: A, B, C with ready low
        applyStimulus(1'b1, 58'h10, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("a_ready", allocReady, 1);
        checkOutput("a_hit", allocHit, 0);
        checkOutput("a_idx", allocIdx, 0);
        step();
        applyStimulus(1'b1, 58'h20, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("b_idx", allocIdx, 1);
        checkOutput("a_reqValid", reqValid, 1);
        checkOutput("a_reqAddr", reqAddr, 58'h10);
        step();
        applyStimulus(1'b1, 58'h30, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("c_idx", allocIdx, 2);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("issue0_id", reqId, 0);
        step();
        checkOutput("issue1_id", reqId, 1);
        checkOutput("issue1_addr", reqAddr, 58'h20);
        step();
        checkOutput("issue2_id", reqId, 2);
        checkOutput("issue2_addr", reqAddr, 58'h30);
        step();
        idle();
        checkOutput("issued_reqValid", reqValid, 0);
        checkOutput("issued_pend", pendCnt, 3);
        checkOutput("issued_empty", empty, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
        step();
        checkOutput("d0_done", done, 1);
        checkOutput("d0_addr", doneAddr, 58'h10);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
        step();
        checkOutput("d2_addr", doneAddr, 58'h30);
        idle();
        step();
        checkOutput("abc_done_clear", done, 0);
        checkOutput("abc_empty", empty, 1);

        // Merging with saturation; one merge coincides with the L2 handshake
        applyStimulus(1'b1, 58'h10, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'h10, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("m1_hit", allocHit, 1);
        checkOutput("m1_idx", allocIdx, 0);
        step();
        applyStimulus(1'b1, 58'h10, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("m2_hit", allocHit, 1);
        step();
        step();
        step();
        idle();
        checkOutput("m_pend", pendCnt, 1);
        checkOutput("m_reqValid", reqValid, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
        step();
        checkOutput("m_done", done, 1);
        checkOutput("m_doneAddr", doneAddr, 58'h10);
        checkOutput("m_doneMerge_sat", doneMerge, 3);
        idle();
        step();

        // Full behaviour and freed-entry reuse
        applyStimulus(1'b1, 58'h100, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'h200, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'h300, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'h400, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("f3_idx", allocIdx, 3);
        step();
        applyStimulus(1'b1, 58'h500, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("full_flag", full, 1);
        checkOutput("full_newReady", allocReady, 0);
        applyStimulus(1'b1, 58'h300, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("full_hitReady", allocReady, 1);
        checkOutput("full_hitIdx", allocIdx, 2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step();
        step();
        step();
        step();
        idle();
        checkOutput("full_pend", pendCnt, 4);
        applyStimulus(1'b1, 58'h500, 1'b0, 1'b1, 2'd2, 1'b0);
        checkOutput("freeing_stall", allocReady, 0);
        step();
        checkOutput("freed_done", done, 1);
        checkOutput("freed_addr", doneAddr, 58'h300);
        checkOutput("freed_full", full, 0);
        applyStimulus(1'b1, 58'h500, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("reuse_ready", allocReady, 1);
        checkOutput("reuse_idx", allocIdx, 2);
        step();
        checkOutput("reuse_full", full, 1);
        checkOutput("reuse_reqId", reqId, 2);
        checkOutput("reuse_reqAddr", reqAddr, 58'h500);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step();
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, IW'(i), 1'b0);
            step();
        end
        idle();
        checkOutput("full_drain_empty", empty, 1);

        // Out-of-order completion
        applyStimulus(1'b1, 58'hA0, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'hB0, 1'b1, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        step();
        checkOutput("ooo1_done", done, 1);
        checkOutput("ooo1_addr", doneAddr, 58'hB0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
        step();
        checkOutput("ooo0_done", done, 1);
        checkOutput("ooo0_addr", doneAddr, 58'hA0);
        checkOutput("ooo_empty", empty, 1);

        // Illegal response ID, then flush against a response and an allocation
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd3, 1'b0);
        step();
        checkOutput("err_pulse", rspErr, 1);
        checkOutput("err_noDone", done, 0);
        idle();
        step();
        checkOutput("err_once", rspErr, 0);
        checkOutput("err_empty", empty, 1);
        applyStimulus(1'b1, 58'hC0, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'hD0, 1'b0, 1'b1, 2'd0, 1'b1);
        step();
        idle();
        checkOutput("flush_done", done, 0);
        checkOutput("flush_err", rspErr, 0);
        checkOutput("flush_empty", empty, 1);
        checkOutput("flush_reqValid", reqValid, 0);
        checkOutput("flush_pend", pendCnt, 0);

        // Asynchronous reset mid-cycle with two refills outstanding
        applyStimulus(1'b1, 58'hE0, 1'b0, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b1, 58'hF0, 1'b1, 1'b0, '0, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step();
        idle();
        checkOutput("pre_rst_pend", pendCnt, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pend", pendCnt, 0);
        checkOutput("arst_empty", empty, 1);
        checkOutput("arst_full", full, 0);
        checkOutput("arst_reqValid", reqValid, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        step();
        checkOutput("arst_lateErr", rspErr, 1);
        checkOutput("arst_lateDone", done, 0);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
